// File: rtl/sweep_pkg.sv
// Shared types and constants for the swept-divider generator.
// Optional feature macro: SWEEP_TRIANGLE_EN (triangle sweep in continuous mode).
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DIV_MIN  = 1;
  localparam int DUTY_MIN = 1;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell timer: counts divider-long periods and pulses expire in the last
// cycle of the dwell-th period after a load.
module sweep_dwell_timer
  import sweep_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] divider,
  input  logic [WIDTH-1:0] dwell,
  output logic             expire
);

  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_dwell;
  logic [WIDTH-1:0] r_cycle_cnt;
  logic [WIDTH-1:0] r_period_cnt;
  logic             w_period_end;
  logic             w_last_period;

  assign w_period_end  = (r_cycle_cnt == r_div - WIDTH'(1));
  assign w_last_period = (r_period_cnt == r_dwell - WIDTH'(1));
  assign expire        = en & w_period_end & w_last_period;

  // Load wins over counting so a restart never inherits a stale count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div        <= WIDTH'(DIV_MIN);
      r_dwell      <= WIDTH'(DIV_MIN);
      r_cycle_cnt  <= '0;
      r_period_cnt <= '0;
    end else if (load) begin
      r_div        <= divider;
      r_dwell      <= dwell;
      r_cycle_cnt  <= '0;
      r_period_cnt <= '0;
    end else if (en) begin
      if (w_period_end) begin
        r_cycle_cnt  <= '0;
        r_period_cnt <= w_last_period ? '0 : r_period_cnt + WIDTH'(1);
      end else begin
        r_cycle_cnt  <= r_cycle_cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/sweep_divider_gen.sv
// Swept pulse-divider generator: steps divider from start to stop on trigger,
// holding each step for dwell periods. Optional macro: SWEEP_TRIANGLE_EN.
module sweep_divider_gen
  import sweep_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trig,
  input  logic [WIDTH-1:0]   start_div,
  input  logic [WIDTH-1:0]   stop_div,
  input  logic [WIDTH-1:0]   step_size,
  input  logic [WIDTH-1:0]   dwell,
  input  logic [FRAC_BITS:0] duty_frac,
  input  logic               continuous,
  output logic [WIDTH-1:0]   divider,
  output logic [WIDTH-1:0]   duty,
  output logic               step_strobe,
  output logic               sweep_active,
  output logic               done
);

  function automatic logic [WIDTH-1:0] guard_zero(input logic [WIDTH-1:0] v);
    return (v == '0) ? WIDTH'(DIV_MIN) : v;
  endfunction

  // One step toward target, clamped to target on overshoot or wrap.
  function automatic logic [WIDTH-1:0] step_toward(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] step,
    input logic [WIDTH-1:0] target,
    input dir_e             dir
  );
    logic [WIDTH:0] ext;
    if (dir == DIR_UP) begin
      ext = {1'b0, cur} + {1'b0, step};
      return (ext[WIDTH] || (ext[WIDTH-1:0] > target)) ? target : ext[WIDTH-1:0];
    end else begin
      ext = {1'b0, cur} - {1'b0, step};
      return (ext[WIDTH] || (ext[WIDTH-1:0] < target)) ? target : ext[WIDTH-1:0];
    end
  endfunction

  function automatic logic [WIDTH-1:0] duty_of(
    input logic [WIDTH-1:0]   d,
    input logic [FRAC_BITS:0] frac
  );
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, d} * {{(2*WIDTH-FRAC_BITS-1){1'b0}}, frac};
    prod = prod >> FRAC_BITS;
    if (prod < (2*WIDTH)'(DUTY_MIN))
      return WIDTH'(DUTY_MIN);
    else if (prod > {{WIDTH{1'b0}}, d})
      return d;
    else
      return prod[WIDTH-1:0];
  endfunction

  state_e             r_state, w_state_next;
  dir_e               r_dir, w_dir_next;
  logic               r_trig_q, r_trig_edge;
  logic [WIDTH-1:0]   r_start, w_start_next;
  logic [WIDTH-1:0]   r_stop, w_stop_next;
  logic [WIDTH-1:0]   r_step, w_step_next;
  logic [WIDTH-1:0]   r_dwell, w_dwell_next;
  logic [FRAC_BITS:0] r_frac, w_frac_next;
  logic               r_cont, w_cont_next;
  logic [WIDTH-1:0]   r_divider, w_divider_next;
  logic [WIDTH-1:0]   r_duty, w_duty_next;
  logic               r_strobe, w_strobe_next;
  logic               w_load;
  logic               w_expire;
  logic [WIDTH-1:0]   w_start_g, w_stop_g;
  logic [WIDTH-1:0]   w_step_fwd;
`ifdef SWEEP_TRIANGLE_EN
  dir_e               w_dir_rev;
  logic [WIDTH-1:0]   w_step_rev;
`endif

  assign w_start_g  = guard_zero(start_div);
  assign w_stop_g   = guard_zero(stop_div);
  assign w_step_fwd = step_toward(r_divider, r_step, r_stop, r_dir);
`ifdef SWEEP_TRIANGLE_EN
  // On the turnaround the old start becomes the new target.
  assign w_dir_rev  = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
  assign w_step_rev = step_toward(r_divider, r_step, r_start, w_dir_rev);
`endif

  sweep_dwell_timer #(.WIDTH(WIDTH)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .en      (r_state == SWEEP),
    .divider (w_divider_next),
    .dwell   (w_dwell_next),
    .expire  (w_expire)
  );

  always_comb begin
    w_state_next   = r_state;
    w_dir_next     = r_dir;
    w_start_next   = r_start;
    w_stop_next    = r_stop;
    w_step_next    = r_step;
    w_dwell_next   = r_dwell;
    w_frac_next    = r_frac;
    w_cont_next    = r_cont;
    w_divider_next = r_divider;
    w_duty_next    = r_duty;
    w_strobe_next  = 1'b0;
    w_load         = 1'b0;

    if (r_trig_edge) begin
      // A trigger restarts from any state with freshly latched config.
      w_start_next   = w_start_g;
      w_stop_next    = w_stop_g;
      w_step_next    = guard_zero(step_size);
      w_dwell_next   = guard_zero(dwell);
      w_frac_next    = duty_frac;
      w_cont_next    = continuous;
      w_dir_next     = (w_stop_g >= w_start_g) ? DIR_UP : DIR_DOWN;
      w_divider_next = w_start_g;
      w_duty_next    = duty_of(w_start_g, duty_frac);
      w_strobe_next  = 1'b1;
      w_load         = 1'b1;
      w_state_next   = SWEEP;
    end else if ((r_state == SWEEP) && w_expire) begin
      if (r_divider == r_stop) begin
        if (r_cont) begin
`ifdef SWEEP_TRIANGLE_EN
          w_start_next   = r_stop;
          w_stop_next    = r_start;
          w_dir_next     = w_dir_rev;
          w_divider_next = w_step_rev;
`else
          w_divider_next = r_start;
`endif
          w_duty_next    = duty_of(w_divider_next, r_frac);
          w_strobe_next  = 1'b1;
          w_load         = 1'b1;
        end else begin
          w_state_next   = DONE;
        end
      end else begin
        w_divider_next = w_step_fwd;
        w_duty_next    = duty_of(w_step_fwd, r_frac);
        w_strobe_next  = 1'b1;
        w_load         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_dir       <= DIR_UP;
      r_trig_q    <= 1'b0;
      r_trig_edge <= 1'b0;
      r_start     <= WIDTH'(DIV_MIN);
      r_stop      <= WIDTH'(DIV_MIN);
      r_step      <= WIDTH'(DIV_MIN);
      r_dwell     <= WIDTH'(DIV_MIN);
      r_frac      <= '0;
      r_cont      <= 1'b0;
      r_divider   <= WIDTH'(DIV_MIN);
      r_duty      <= WIDTH'(DUTY_MIN);
      r_strobe    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_dir       <= w_dir_next;
      r_trig_q    <= trig;
      r_trig_edge <= trig & ~r_trig_q;
      r_start     <= w_start_next;
      r_stop      <= w_stop_next;
      r_step      <= w_step_next;
      r_dwell     <= w_dwell_next;
      r_frac      <= w_frac_next;
      r_cont      <= w_cont_next;
      r_divider   <= w_divider_next;
      r_duty      <= w_duty_next;
      r_strobe    <= w_strobe_next;
    end
  end

  assign divider      = r_divider;
  assign duty         = r_duty;
  assign step_strobe  = r_strobe;
  assign sweep_active = (r_state == SWEEP);
  assign done         = (r_state == DONE);

endmodule
